// File: rtl/cart_load_ctrl.sv
// cart_load_ctrl: sequences cartridge downloads into ROM RAM port A and holds the core in reset until done.
// Define CART_MIRROR_EN to replicate images shorter than MIRROR_SIZE up to MIRROR_SIZE bytes.
module cart_load_ctrl #(
  parameter int HOLD_CYCLES = 16,
  parameter int MIRROR_SIZE = 4096
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic [31:0] ioctl_file_ext,
  input  logic        sc_en,
  output logic [15:0] ram_a,
  output logic [7:0]  ram_d,
  output logic        ram_we,
  input  logic [7:0]  ram_q,
  output logic        core_reset,
  output logic [3:0]  force_bs,
  output logic        sc,
  output logic [16:0] rom_size,
  output logic        loaded
);
`ifdef CART_MIRROR_EN
  localparam logic MIRROR = 1'b1;
`else
  localparam logic MIRROR = 1'b0;
`endif
  localparam logic [2:0] IDLE = 3'd0, LOAD = 3'd1, PAD_RD = 3'd2, PAD_WR = 3'd3, HOLD = 3'd4;
  localparam int CW = $clog2(HOLD_CYCLES + 1);
  localparam logic [16:0] MSZ = 17'(MIRROR_SIZE);
  logic [2:0] state_q, state_d;
  logic dl_q;
  logic [16:0] ptr_q, ptr_d, size_q, size_d, wr_size, base_size;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0] a_q, a_d;
  logic [7:0] d_q, d_d;
  logic we_q, we_d;
  logic [3:0] bs_q, bs_d, ext_bs;
  logic sc_q, sc_d, loaded_q, loaded_d;
  logic rise, fall, in_load, wr_ok;
  logic unused_ext;
  assign unused_ext = ^ioctl_file_ext[31:24];
  assign rise = ioctl_download & ~dl_q;
  assign fall = ~ioctl_download & dl_q;
  assign in_load = rise | (state_q == LOAD);
  assign wr_ok = in_load & ioctl_download & ioctl_wr & (ioctl_addr[24:16] == '0);
  assign base_size = rise ? '0 : size_q;
  assign wr_size = {1'b0, ioctl_addr[15:0]} + 17'd1;
  always_comb begin
    ext_bs = 4'd0;
    case (ioctl_file_ext[23:0])
      ".F8": ext_bs = 4'd1;
      ".F6": ext_bs = 4'd2;
      ".FE": ext_bs = 4'd3;
      ".E0": ext_bs = 4'd4;
      ".3F": ext_bs = 4'd5;
      ".F4": ext_bs = 4'd6;
      ".P2": ext_bs = 4'd7;
      ".FA": ext_bs = 4'd8;
      ".CV": ext_bs = 4'd9;
      default: ext_bs = 4'd0;
    endcase
  end
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    a_d = a_q;
    d_d = d_q;
    we_d = 1'b0;
    bs_d = bs_q;
    sc_d = sc_q;
    loaded_d = loaded_q;
    size_d = size_q;
    case (state_q)
      LOAD: if (fall) begin
        cnt_d = '0;
        ptr_d = size_q;
        a_d = '0;
        state_d = (size_q == '0) ? IDLE : (MIRROR && size_q < MSZ) ? PAD_RD : HOLD;
      end
      PAD_RD: begin
        state_d = PAD_WR;
        a_d = ptr_q[15:0];
        we_d = 1'b1;
      end
      PAD_WR: begin
        ptr_d = ptr_q + 17'd1;
        a_d = 16'(ptr_d - size_q);
        state_d = (ptr_d == MSZ) ? HOLD : PAD_RD;
      end
      HOLD: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
          state_d = IDLE;
          loaded_d = 1'b1;
        end
      end
      default: ;
    endcase
    // A new download aborts padding or hold and re-captures the latches
    if (rise) begin
      state_d = LOAD;
      loaded_d = 1'b0;
      sc_d = sc_en;
      bs_d = ext_bs;
      we_d = 1'b0;
    end
    if (in_load) begin
      size_d = (wr_ok && wr_size > base_size) ? wr_size : base_size;
      if (wr_ok) begin
        a_d = ioctl_addr[15:0];
        d_d = ioctl_dout;
        we_d = 1'b1;
      end
    end
  end
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= IDLE;
      dl_q <= 1'b0;
      ptr_q <= '0;
      cnt_q <= '0;
      a_q <= '0;
      d_q <= '0;
      we_q <= 1'b0;
      bs_q <= '0;
      sc_q <= 1'b0;
      loaded_q <= 1'b0;
      size_q <= '0;
    end else begin
      state_q <= state_d;
      dl_q <= ioctl_download;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      a_q <= a_d;
      d_q <= d_d;
      we_q <= we_d;
      bs_q <= bs_d;
      sc_q <= sc_d;
      loaded_q <= loaded_d;
      size_q <= size_d;
    end
  end
  // Pad writes forward the byte read in the preceding PAD_RD cycle straight from the RAM
  assign ram_d = (MIRROR && state_q == PAD_WR) ? ram_q : d_q;
  assign ram_a = a_q;
  assign ram_we = we_q;
  assign core_reset = ~loaded_q;
  assign force_bs = bs_q;
  assign sc = sc_q;
  assign rom_size = size_q;
  assign loaded = loaded_q;
endmodule
